// File: rtl/mandelbrot_pkg.sv
// Shared defaults and state encoding for the mandelbrot frame scheduler.
package mandelbrot_pkg;

    localparam int DEF_FPW     = 54;
    localparam int DEF_AW      = 11;
    localparam int DEF_CW      = 12;
    localparam int DEF_MAXINFL = 64;

    // state   | meaning
    // IDLE    | waiting for start, outputs quiet
    // RUN     | walking the raster, offering one coordinate per handshake
    // DRAIN   | all pixels issued, waiting for in-flight results to return
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mandelbrot_infl_cnt.sv
// Saturating up/down counter of pixels issued to the pipeline but not yet returned.
module mandelbrot_infl_cnt #(
    parameter int MAXINFL = 64,
    parameter int IFW     = $clog2(MAXINFL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic at_max,
    output logic zero_next
);

    logic [IFW-1:0] cnt;
    logic           inc_ok;
    logic           dec_ok;

    assign at_max    = (cnt == IFW'(MAXINFL));
    // a return with nothing outstanding belongs to no frame of ours
    assign dec_ok    = dec && (cnt != '0);
    assign inc_ok    = inc && (!at_max || dec_ok);
    assign zero_next = !inc && ((cnt == '0) || ((cnt == IFW'(1)) && dec));

    // count issues up and returns down; simultaneous pair cancels
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + IFW'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - IFW'(1);
        end
    end

endmodule

// File: rtl/mandelbrot_frame_sched.sv
// Frame scheduler: latches a frame, walks it in raster order into the pipeline,
// and signals done once every issued pixel has come back out.
module mandelbrot_frame_sched
    import mandelbrot_pkg::*;
#(
    parameter int FPW     = DEF_FPW,
    parameter int AW      = DEF_AW,
    parameter int CW      = DEF_CW,
    parameter int MAXINFL = DEF_MAXINFL,
    parameter int IFW     = $clog2(MAXINFL + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           start,
    input  logic [FPW-1:0] x0,
    input  logic [FPW-1:0] y0,
    input  logic [FPW-1:0] dx,
    input  logic [FPW-1:0] dy,
    input  logic [CW-1:0]  hres,
    input  logic [CW-1:0]  vres,
    output logic           busy,
    output logic           done,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [FPW-1:0] x_man,
    output logic [FPW-1:0] y_man,
    output logic [AW-1:0]  adr_o,
    input  logic           res_vld,
    input  logic           res_rdy
);

    state_t         state;
    state_t         state_nxt;
    logic [FPW-1:0] x0_q;
    logic [FPW-1:0] dx_q;
    logic [FPW-1:0] dy_q;
    logic [CW-1:0]  hres_q;
    logic [CW-1:0]  vres_q;
    logic [CW-1:0]  col;
    logic [CW-1:0]  row;
    logic           at_max;
    logic           zero_next;
    logic           issue;
    logic           ret;
    logic           load;
    logic           fin;
    logic           last_col;
    logic           last_pix;

    assign ret      = res_vld & res_rdy & clk_en;
    assign last_col = (col == hres_q - CW'(1));
    assign last_pix = last_col && (row == vres_q - CW'(1));

    mandelbrot_infl_cnt #(
        .MAXINFL (MAXINFL),
        .IFW     (IFW)
    ) u_infl (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue),
        .dec       (ret),
        .at_max    (at_max),
        .zero_next (zero_next)
    );

    // next-state and handshake decode from the registered state
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fin       = 1'b0;
        out_vld   = (state == ST_RUN) && !at_max;
        issue     = out_vld && out_rdy && clk_en;
        case (state)
            ST_IDLE: begin
                if (clk_en && start) begin
                    load      = 1'b1;
                    state_nxt = ((hres == '0) || (vres == '0)) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_pix) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (clk_en && zero_next) begin
                    fin       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // frame latch, raster walker and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q   <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            hres_q <= '0;
            vres_q <= '0;
            col    <= '0;
            row    <= '0;
            x_man  <= '0;
            y_man  <= '0;
            adr_o  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (clk_en) begin
            done <= fin;
            if (load) begin
                x0_q   <= x0;
                dx_q   <= dx;
                dy_q   <= dy;
                hres_q <= hres;
                vres_q <= vres;
                col    <= '0;
                row    <= '0;
                x_man  <= x0;
                y_man  <= y0;
                adr_o  <= '0;
                busy   <= 1'b1;
            end else begin
                if (fin) begin
                    busy <= 1'b0;
                end
                if (issue) begin
                    adr_o <= adr_o + AW'(1);
                    if (!last_col) begin
                        col   <= col + CW'(1);
                        x_man <= x_man + dx_q;
                    end else begin
                        col   <= '0;
                        x_man <= x0_q;
                        row   <= row + CW'(1);
                        y_man <= y_man + dy_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame_sched.sv
// Directed bench for the frame scheduler: raster order, backpressure, in-flight cap,
// empty frames, ignored restart, clock-enable freeze and mid-frame reset.
module tb_mandelbrot_frame_sched;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic        start4;
    logic [53:0] x0;
    logic [53:0] y0;
    logic [53:0] dx;
    logic [53:0] dy;
    logic [11:0] hres;
    logic [11:0] vres;
    logic        busy;
    logic        done;
    logic        out_vld;
    logic        out_rdy;
    logic [53:0] x_man;
    logic [53:0] y_man;
    logic [10:0] adr_o;
    logic        res_vld;
    logic        res_rdy;
    logic        busy4;
    logic        done4;
    logic        out_vld4;
    logic        out_rdy4;
    logic [53:0] x_man4;
    logic [53:0] y_man4;
    logic [10:0] adr_o4;
    logic        res_vld4;

    int n_cmp = 0;
    int n_bad = 0;

    mandelbrot_frame_sched dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .start   (start),
        .x0      (x0),
        .y0      (y0),
        .dx      (dx),
        .dy      (dy),
        .hres    (hres),
        .vres    (vres),
        .busy    (busy),
        .done    (done),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .x_man   (x_man),
        .y_man   (y_man),
        .adr_o   (adr_o),
        .res_vld (res_vld),
        .res_rdy (res_rdy)
    );

    mandelbrot_frame_sched #(.MAXINFL(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .start   (start4),
        .x0      (x0),
        .y0      (y0),
        .dx      (dx),
        .dy      (dy),
        .hres    (hres),
        .vres    (vres),
        .busy    (busy4),
        .done    (done4),
        .out_vld (out_vld4),
        .out_rdy (out_rdy4),
        .x_man   (x_man4),
        .y_man   (y_man4),
        .adr_o   (adr_o4),
        .res_vld (res_vld4),
        .res_rdy (res_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One frame on the 64-deep instance. Results loop back lat cycles after issue.
    // mid: cycle at which a stray start (with garbage frame inputs) is pulsed, -1 none.
    // gate: first of three cycles with clk_en low, -1 none.
    task automatic run_frame(input string tag, input int h, input int v,
                             input logic [53:0] fx0, input logic [53:0] fy0,
                             input logic [53:0] fdx, input logic [53:0] fdy,
                             input bit rnd, input int mid, input int gate, input int lat);
        int          n_iss    = 0;
        int          n_ret    = 0;
        int          ret_last = -10;
        int          fin_cyc  = -1;
        bit          fin_seen = 0;
        int          c        = 0;
        int          q[$];
        int          col;
        int          row;
        bit          want_vld;
        bit          want_done;
        bit          want_busy;
        logic [53:0] ex;
        logic [53:0] ey;
        x0   = fx0;
        y0   = fy0;
        dx   = fdx;
        dy   = fdy;
        hres = 12'(h);
        vres = 12'(v);
        while (c < 400 && !(fin_seen && c >= fin_cyc + 2)) begin
            @(negedge clk);
            start = (c == 0) || (c == mid);
            if (c == mid) begin
                x0   = ~fx0;
                hres = '0;
            end
            clk_en  = !(gate >= 0 && c >= gate && c < gate + 3);
            out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            res_vld = (q.size() > 0) && (q[0] <= c);
            #1;
            want_vld  = (c >= 1) && (n_iss < h * v);
            want_done = (c >= 1) && !fin_seen &&
                        ((h * v == 0) ? (c == 2) : (n_ret == h * v && ret_last == c - 1));
            if (want_done) begin
                fin_seen = 1'b1;
                fin_cyc  = c;
            end
            want_busy = (c >= 1) && !fin_seen;
            chk({tag, "_vld"}, 64'(out_vld), 64'(want_vld));
            chk({tag, "_done"}, 64'(done), 64'(want_done));
            chk({tag, "_busy"}, 64'(busy), 64'(want_busy));
            if (want_vld && out_vld) begin
                col = n_iss % h;
                row = n_iss / h;
                ex  = fx0 + 54'(col) * fdx;
                ey  = fy0 + 54'(row) * fdy;
                chk({tag, "_x"}, 64'(x_man), 64'(ex));
                chk({tag, "_y"}, 64'(y_man), 64'(ey));
                chk({tag, "_adr"}, 64'(adr_o), 64'(11'(n_iss)));
            end
            if (out_vld && out_rdy && clk_en) begin
                q.push_back(c + lat);
                n_iss++;
            end
            if (res_vld && res_rdy && clk_en) begin
                void'(q.pop_front());
                n_ret++;
                ret_last = c;
            end
            c++;
        end
        start   = 1'b0;
        clk_en  = 1'b1;
        out_rdy = 1'b0;
        res_vld = 1'b0;
        chk({tag, "_issues"}, 64'(n_iss), 64'(h * v));
        chk({tag, "_returns"}, 64'(n_ret), 64'(h * v));
        chk({tag, "_finished"}, 64'(fin_seen), 64'(1));
    endtask

    initial begin
        int iss4;
        rst      = 1'b1;
        clk_en   = 1'b1;
        start    = 1'b0;
        start4   = 1'b0;
        out_rdy  = 1'b0;
        out_rdy4 = 1'b0;
        res_vld  = 1'b0;
        res_vld4 = 1'b0;
        res_rdy  = 1'b1;
        x0 = '0; y0 = '0; dx = '0; dy = '0; hres = '0; vres = '0;

        repeat (3) @(negedge clk);
        chk("rst_vld", 64'(out_vld), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_adr", 64'(adr_o), 64'(0));
        chk("rst_x", 64'(x_man), 64'(0));
        chk("rst_y", 64'(y_man), 64'(0));
        chk("rst4_vld", 64'(out_vld4), 64'(0));
        rst = 1'b0;

        run_frame("basic", 3, 2, 54'd0, 54'd0, 54'd1, 54'd1, 1'b0, -1, -1, 5);
        run_frame("bp", 3, 2, 54'd0, 54'd0, 54'd1, 54'd1, 1'b1, -1, -1, 5);
        run_frame("bp2", 5, 3, -54'sd7, 54'd20, 54'd3, -54'sd2, 1'b1, -1, -1, 4);
        run_frame("hzero", 0, 2, 54'd5, 54'd5, 54'd1, 54'd1, 1'b0, -1, -1, 5);
        run_frame("vzero", 4, 0, 54'd5, 54'd5, 54'd1, 54'd1, 1'b0, -1, -1, 5);
        run_frame("restart", 4, 3, -54'sd100, 54'd9, 54'd25, 54'd1000, 1'b0, 3, -1, 5);
        run_frame("gate", 3, 3, 54'h1F_FFFF_FFFF_FFFE, -54'sd1, 54'd1, -54'sd1, 1'b0, -1, 3, 5);

        // in-flight cap on the 4-deep instance, results withheld
        @(negedge clk);
        x0 = 54'd0; y0 = 54'd0; dx = 54'd1; dy = 54'd1; hres = 12'd4; vres = 12'd4;
        start4 = 1'b1;
        iss4   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start4   = 1'b0;
            out_rdy4 = 1'b1;
            res_vld4 = 1'b0;
            #1;
            if (out_vld4 && out_rdy4 && clk_en) iss4++;
        end
        chk("cap_issues", 64'(iss4), 64'(4));
        chk("cap_vld", 64'(out_vld4), 64'(0));
        chk("cap_adr", 64'(adr_o4), 64'(4));
        @(negedge clk);
        res_vld4 = 1'b1;
        #1;
        if (out_vld4 && out_rdy4 && clk_en) iss4++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            res_vld4 = 1'b0;
            #1;
            if (out_vld4 && out_rdy4 && clk_en) iss4++;
        end
        chk("release_issues", 64'(iss4), 64'(5));
        chk("release_adr", 64'(adr_o4), 64'(5));
        chk("release_x", 64'(x_man4), 64'(1));
        chk("release_y", 64'(y_man4), 64'(1));
        out_rdy4 = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("cap_rst_busy", 64'(busy4), 64'(0));

        // reset in the middle of a frame with three pixels outstanding
        @(negedge clk);
        x0 = 54'd100; y0 = 54'd200; dx = 54'd1; dy = 54'd1; hres = 12'd8; vres = 12'd2;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start   = 1'b0;
            out_rdy = 1'b1;
        end
        @(negedge clk);
        #1;
        chk("mid_adr", 64'(adr_o), 64'(3));
        chk("mid_x", 64'(x_man), 64'(103));
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        out_rdy = 1'b0;
        #1;
        chk("mrst_vld", 64'(out_vld), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_adr", 64'(adr_o), 64'(0));
        chk("mrst_x", 64'(x_man), 64'(0));
        chk("mrst_done", 64'(done), 64'(0));
        run_frame("after_rst", 2, 2, 54'd40, 54'd50, 54'd2, 54'd3, 1'b0, -1, -1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mandelbrot_frame_sched.md
Name: mandelbrot_frame_sched

Overview:
- Frame scheduler in front of the mandelbrot calculation pipeline wrapper.
- On a start pulse it latches a frame description: origin, per-pixel step and resolution.
- It then streams one (x, y, address) coordinate per accepted handshake, in raster order, into the pipeline input.
- It snoops the pipeline result handshake to track in-flight work, and pulses done once every issued pixel has returned.

Parameters:
- FPW, 54, bitwidth of signed fixed-point coordinates and steps
- AW, 11, address width, matching the pipeline address tag
- CW, 12, width of the column/row counters and resolution inputs
- MAXINFL, 64, maximum number of pixels in flight (issued, not yet returned)
- IFW, $clog2(MAXINFL+1), width of the in-flight counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  clock enable; when low, all state holds
- start  in  1  single-cycle frame start request
- x0  in  FPW  signed x of pixel (0,0)
- y0  in  FPW  signed y of pixel (0,0)
- dx  in  FPW  signed x increment per column
- dy  in  FPW  signed y increment per row
- hres  in  CW  pixels per row
- vres  in  CW  rows per frame
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the frame is complete
- out_vld  out  1  coordinate valid, to pipeline in_vld
- out_rdy  in  1  pipeline in_rdy
- x_man  out  FPW  coordinate x
- y_man  out  FPW  coordinate y
- adr_o  out  AW  pixel index modulo 2^AW
- res_vld  in  1  pipeline out_vld (observed)
- res_rdy  in  1  consumer out_rdy (observed)

Behaviour:
- Clock is clk. rst is synchronous and active-high, and takes priority over clk_en.
- Reset values: state=IDLE; busy=0; done=0; out_vld=0; x_man=0; y_man=0; adr_o=0; counters=0.
- With clk_en=0, nothing updates; done holds its value; handshakes count only when clk_en=1.
- Issue = out_vld & out_rdy & clk_en.
- Return = res_vld & res_rdy & clk_en.
- States: IDLE, RUN, DRAIN.
- IDLE, on start:
  - Latch x0, y0, dx, dy, hres and vres.
  - Set x_man=x0, y_man=y0, adr_o=0, col=0, row=0.
  - Set busy=1.
  - If hres==0 or vres==0, go to DRAIN; otherwise go to RUN.
- start outside IDLE is ignored.
- RUN:
  - out_vld = (infl != MAXINFL). This is registered; it may also be combinational from the registered state and infl.
  - On issue, adr_o increments and wraps mod 2^AW.
  - If col != hres-1: col++, x_man += dx.
  - Else: col=0, x_man=x0, row++, y_man += dy.
  - Issuing pixel (hres-1, vres-1) moves to DRAIN with out_vld=0 from the next cycle.
  - Adds are FPW-bit two's complement; overflow wraps silently.
- infl:
  - Increments on issue and decrements on return.
  - Simultaneous issue and return leaves infl unchanged.
  - Never exceeds MAXINFL.
  - A return with infl==0 is ignored (no underflow).
- DRAIN: when infl==0, or infl==1 with a return this cycle, pulse done=1 for one enabled cycle, set busy=0 and go to IDLE.
- First issue latency: coordinate valid on the cycle after start. Throughput is one pixel per cycle while out_rdy=1 and infl<MAXINFL.
- out_vld, once high, stays high with stable x_man/y_man/adr_o until issue.
- Reset mid-frame: everything returns to reset values immediately. Results still in the pipeline are not tracked; the pipeline is reset by the same rst.

Decomposition:
- Shared package mandelbrot_pkg: FPW, AW and CW defaults; state encoding localparams for IDLE/RUN/DRAIN.
- One natural sub-module, mandelbrot_infl_cnt: the saturating up/down in-flight counter with an at_max flag and a zero_next flag.
- Raster walker and FSM stay in the top.

Test Plan:
- Reset, then start with hres=3, vres=2, x0=0, y0=0, dx=1, dy=1, out_rdy=1, results looped back after 5 cycles:
  - Required coordinates: (0,0)(1,0)(2,0)(0,1)(1,1)(2,1).
  - Required adr_o: 0..5.
  - done pulses once, in the cycle after the 6th return; busy falls with it.
- Backpressure: out_rdy toggles randomly, same frame → identical coordinate sequence, values stable while out_vld=1 & out_rdy=0, no duplicates or drops.
- MAXINFL=4 with res_vld held low → exactly 4 issues then out_vld=0. Release one return → exactly one more issue.
- hres=0 (or vres=0) start → zero issues, done pulses after IDLE→DRAIN, i.e. 2 cycles after start.
- start pulsed during RUN → ignored, frame sequence unchanged. clk_en low for 3 cycles mid-frame → all outputs frozen, and sequence resumes intact.
- Assert rst mid-RUN with infl=3 → next cycle out_vld=0, busy=0, adr_o=0. A fresh start produces coordinates from (x0,y0).
